// File: rtl/axi_wr_slave_resp.sv
// ============================================================================
// Module : axi_wr_slave_resp
// Brief  : AXI write-path sink. Takes one AW burst at a time, checks the W beats
//          against it and returns one B response. Write data is not stored.
//          Optional statistics counters are enabled by AXI_WR_SLAVE_STATS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_wr_slave_resp #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  sig_clock,
  input  logic                  sig_reset,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ID_WIDTH-1:0]   wid,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [ID_WIDTH-1:0]   bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready
`ifdef AXI_WR_SLAVE_STATS_EN
  ,
  output logic [31:0]           stat_bursts,
  output logic [31:0]           stat_errors
`endif
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_DATA = 2'd1;
  localparam logic [1:0] c_RESP = 2'd2;

  logic [1:0]            state_q,   state_d;
  logic                  awready_q, awready_d;
  logic                  wready_q,  wready_d;
  logic                  bvalid_q,  bvalid_d;
  logic [ID_WIDTH-1:0]   bid_q,     bid_d;
  logic [1:0]            bresp_q,   bresp_d;
  logic [ID_WIDTH-1:0]   id_q,      id_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic [7:0]            len_q,     len_d;
  logic [2:0]            size_q,    size_d;
  logic [1:0]            burst_q,   burst_d;
  logic [8:0]            cnt_q,     cnt_d;
  logic                  err_q,     err_d;

  logic [7:0] w_size_bytes;
  logic       w_aw_bad;
  logic       w_beat_bad;
  logic       w_unused;

  assign w_size_bytes = 8'd1 << awsize;
  assign w_aw_bad     = (awburst == 2'b11) || ({1'b0, w_size_bytes} > 9'(STRB_WIDTH));

  // cnt_q is the index of the beat currently being presented
  assign w_beat_bad = (wid != id_q)
                   || ( wlast && (cnt_q <  {1'b0, len_q}))
                   || (!wlast && (cnt_q == {1'b0, len_q}));

  assign w_unused = ^{wdata, wstrb, addr_q, size_q, burst_q};

  always_comb begin
    state_d   = state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    case (state_q)
      c_IDLE: begin
        awready_d = 1'b1;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
        if (awvalid && awready_q) begin
          id_d      = awid;
          addr_d    = awaddr;
          len_d     = awlen;
          size_d    = awsize;
          burst_d   = awburst;
          cnt_d     = 9'd0;
          err_d     = w_aw_bad;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          state_d   = c_DATA;
        end
      end
      c_DATA: begin
        if (wvalid && wready_q) begin
          if (cnt_q != 9'd256) cnt_d = cnt_q + 9'd1;
          err_d = err_q || w_beat_bad;
          if (wlast) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bid_d    = id_q;
            bresp_d  = (err_q || w_beat_bad) ? 2'b10 : 2'b00;
            state_d  = c_RESP;
          end
        end
      end
      c_RESP: begin
        if (bready && bvalid_q) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          state_d   = c_IDLE;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge sig_clock) begin
    if (sig_reset) begin
      state_q   <= c_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= 2'b00;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= 8'd0;
      size_q    <= 3'd0;
      burst_q   <= 2'b00;
      cnt_q     <= 9'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;

`ifdef AXI_WR_SLAVE_STATS_EN
  logic [31:0] bursts_q, errors_q;

  always_ff @(posedge sig_clock) begin
    if (sig_reset) begin
      bursts_q <= 32'd0;
      errors_q <= 32'd0;
    end else if (bvalid_q && bready) begin
      bursts_q <= bursts_q + 32'd1;
      if (bresp_q == 2'b10) errors_q <= errors_q + 32'd1;
    end
  end

  assign stat_bursts = bursts_q;
  assign stat_errors = errors_q;
`endif

endmodule

`default_nettype wire
